// File: rtl/trace_pkg.sv
// Commit trace buffer shared types: FSM states and packed entry layout.
// Entry is {pc, inst, rd, regwrite, wdata} with pc in the MSBs.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  function automatic int entry_w(int xlen);
    return 2 * xlen + 38;
  endfunction

  function automatic int off_wdata(int xlen);
    return 0 * xlen;
  endfunction

  function automatic int off_regwrite(int xlen);
    return xlen;
  endfunction

  function automatic int off_rd(int xlen);
    return xlen + 1;
  endfunction

  function automatic int off_inst(int xlen);
    return xlen + 6;
  endfunction

  function automatic int off_pc(int xlen);
    return xlen + 38;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Readout handshake bundle of the commit trace buffer.
// master drives valid/data, slave drives ready.
interface commit_trace_buffer_if #(
  parameter int XLEN = 32
) ();
  import trace_pkg::*;

  logic                     rd_valid;
  logic                     rd_ready;
  logic [entry_w(XLEN)-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 102,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired instructions around a
// trigger into a circular RAM, then freezes for oldest-first readout.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int POST_COUNT = 4,
  parameter int WRAP       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_valid,
  input  logic [XLEN-1:0]        cap_pc,
  input  logic [31:0]            cap_inst,
  input  logic [4:0]             cap_rd,
  input  logic                   cap_regwrite,
  input  logic [XLEN-1:0]        cap_wdata,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic                   force_trig,
  commit_trace_buffer_if.master  rd,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   triggered,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(XLEN);

  trace_state_t  st_q, st_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] post_q, post_d;
  logic          trg_q, trg_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          cap;
  logic          trig;
  logic          hs;
  logic          we;
  logic [EW-1:0] entry;
  logic [EW-1:0] rdata;

  assign full  = cnt_q == CW'(DEPTH);
  assign cap   = cap_valid && (st_q == ARMED || st_q == POST);
  assign trig  = st_q == ARMED &&
                 (force_trig ||
                  (cap_valid && trig_en && cap_pc == trig_pc));
  assign hs    = rd.rd_valid && rd.rd_ready;
  assign we    = cap && !arm && (!full || WRAP != 0);
  assign entry = {cap_pc, cap_inst, cap_rd, cap_regwrite, cap_wdata};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_q),
    .wdata (entry),
    .raddr (rp_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      wr_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      post_q <= '0;
      trg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      post_q <= post_d;
      trg_q  <= trg_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    wr_d   = wr_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    post_d = post_q;
    trg_d  = trg_q;
    ovf_d  = ovf_q;
    if (arm) begin
      st_d   = ARMED;
      wr_d   = '0;
      rp_d   = '0;
      cnt_d  = '0;
      post_d = '0;
      trg_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
        end
        ARMED, POST: begin
          if (cap) begin
            if (!full) begin
              wr_d  = wr_q + 1'b1;
              cnt_d = cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
              // oldest entry is overwritten, so the read side follows
              if (WRAP != 0) begin
                wr_d = wr_q + 1'b1;
                rp_d = rp_q + 1'b1;
              end
            end
          end
          if (trig) begin
            trg_d  = 1'b1;
            post_d = CW'(POST_COUNT);
            if (POST_COUNT > 0) st_d = POST;
            else                st_d = FROZEN;
          end else if (st_q == POST && cap) begin
            post_d = post_q - 1'b1;
            if (post_q == CW'(1)) st_d = FROZEN;
          end
        end
        FROZEN: begin
          if (cnt_q == '0) begin
            st_d = IDLE;
          end else if (hs) begin
            rp_d  = rp_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) st_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd.rd_valid = st_q == FROZEN && cnt_q != '0;
  assign rd.rd_data  = rdata;
  assign state       = st_q;
  assign count       = cnt_q;
  assign triggered   = trg_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench: three buffer configs sharing capture stimulus,
// each checked on its own scenario with hand-computed expectations.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int XLEN   = 32;
  localparam int PC_LSB = off_pc(XLEN);

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_valid;
  logic [31:0] cap_pc;
  logic [31:0] cap_inst;
  logic [4:0]  cap_rd;
  logic        cap_regwrite;
  logic [31:0] cap_wdata;
  logic        arm;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        force_trig;

  logic [1:0] st_a, st_b, st_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       trg_a, trg_b, trg_c;
  logic       ovf_a, ovf_b, ovf_c;

  int errors = 0;
  int checks = 0;

  commit_trace_buffer_if #(.XLEN(XLEN)) ia ();
  commit_trace_buffer_if #(.XLEN(XLEN)) ib ();
  commit_trace_buffer_if #(.XLEN(XLEN)) ic ();

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(8), .POST_COUNT(2), .WRAP(1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_inst(cap_inst), .cap_rd(cap_rd),
    .cap_regwrite(cap_regwrite), .cap_wdata(cap_wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .rd(ia),
    .state(st_a), .count(cnt_a),
    .triggered(trg_a), .overflow(ovf_a)
  );

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(8), .POST_COUNT(2), .WRAP(0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_inst(cap_inst), .cap_rd(cap_rd),
    .cap_regwrite(cap_regwrite), .cap_wdata(cap_wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .rd(ib),
    .state(st_b), .count(cnt_b),
    .triggered(trg_b), .overflow(ovf_b)
  );

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(8), .POST_COUNT(0), .WRAP(1)
  ) dut_c (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_inst(cap_inst), .cap_rd(cap_rd),
    .cap_regwrite(cap_regwrite), .cap_wdata(cap_wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .rd(ic),
    .state(st_c), .count(cnt_c),
    .triggered(trg_c), .overflow(ovf_c)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic capture(input logic [31:0] pc);
    cap_valid    = 1'b1;
    cap_pc       = pc;
    cap_inst     = ~pc;
    cap_rd       = 5'd7;
    cap_regwrite = 1'b1;
    cap_wdata    = pc + 32'd1;
    tick();
    cap_valid    = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic [31:0] pc);
    logic [101:0] d;
    d = ia.rd_data;
    chk({tag, "_valid"}, 128'(ia.rd_valid), 128'(1));
    chk({tag, "_pc"}, 128'(d[PC_LSB +: 32]), 128'(pc));
    ia.rd_ready = 1'b1;
    tick();
    ia.rd_ready = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [31:0] pc);
    logic [101:0] d;
    d = ib.rd_data;
    chk({tag, "_valid"}, 128'(ib.rd_valid), 128'(1));
    chk({tag, "_pc"}, 128'(d[PC_LSB +: 32]), 128'(pc));
    ib.rd_ready = 1'b1;
    tick();
    ib.rd_ready = 1'b0;
  endtask

  initial begin
    logic [101:0] exp_c;
    reset        = 1'b0;
    cap_valid    = 1'b0;
    cap_pc       = '0;
    cap_inst     = '0;
    cap_rd       = '0;
    cap_regwrite = 1'b0;
    cap_wdata    = '0;
    arm          = 1'b0;
    trig_en      = 1'b0;
    trig_pc      = '0;
    force_trig   = 1'b0;
    ia.rd_ready  = 1'b0;
    ib.rd_ready  = 1'b0;
    ic.rd_ready  = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_state_a", 128'(st_a), 128'(0));
    chk("rst_state_c", 128'(st_c), 128'(0));
    chk("rst_count_a", 128'(cnt_a), 128'(0));
    chk("rst_valid_a", 128'(ia.rd_valid), 128'(0));
    reset = 1'b1;
    tick();

    // captures ignored while idle
    capture(32'h0);
    chk("idle_count", 128'(cnt_a), 128'(0));

    // basic trigger with post window
    trig_en = 1'b1;
    trig_pc = 32'h10;
    do_arm();
    chk("b1_armed", 128'(st_a), 128'(1));
    for (int i = 0; i < 5; i++) capture(32'(4 * i));
    chk("b1_post", 128'(st_a), 128'(2));
    chk("b1_trg", 128'(trg_a), 128'(1));
    capture(32'h14);
    chk("b1_post2", 128'(st_a), 128'(2));
    capture(32'h18);
    chk("b1_frozen", 128'(st_a), 128'(3));
    chk("b1_count", 128'(cnt_a), 128'(7));
    chk("b1_ovf", 128'(ovf_a), 128'(0));
    capture(32'h99);
    chk("b1_frz_ign", 128'(cnt_a), 128'(7));
    for (int i = 0; i < 7; i++) pop_a("b1_rd", 32'(4 * i));
    chk("b1_idle", 128'(st_a), 128'(0));
    chk("b1_novalid", 128'(ia.rd_valid), 128'(0));

    // wrap: keep last 8
    trig_pc = 32'h40;
    do_arm();
    for (int i = 0; i <= 18; i++) capture(32'(4 * i));
    chk("w_frozen", 128'(st_a), 128'(3));
    chk("w_count", 128'(cnt_a), 128'(8));
    chk("w_ovf", 128'(ovf_a), 128'(1));
    for (int i = 0; i < 8; i++) pop_a("w_rd", 32'(32'h2C + 4 * i));
    chk("w_idle", 128'(st_a), 128'(0));

    // no-wrap drop plus force trigger
    trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 10; i++) capture(32'(32'h100 + 4 * i));
    chk("nw_armed", 128'(st_b), 128'(1));
    chk("nw_count", 128'(cnt_b), 128'(8));
    chk("nw_ovf", 128'(ovf_b), 128'(1));
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("nw_post", 128'(st_b), 128'(2));
    chk("nw_trg", 128'(trg_b), 128'(1));
    capture(32'h300);
    capture(32'h304);
    chk("nw_frozen", 128'(st_b), 128'(3));
    chk("nw_count2", 128'(cnt_b), 128'(8));
    for (int i = 0; i < 8; i++) pop_b("nw_rd", 32'(32'h100 + 4 * i));
    chk("nw_idle", 128'(st_b), 128'(0));

    // zero post window, stalled readout
    trig_en = 1'b1;
    trig_pc = 32'h200;
    do_arm();
    capture(32'h200);
    chk("z_frozen", 128'(st_c), 128'(3));
    chk("z_count", 128'(cnt_c), 128'(1));
    exp_c = {32'h200, ~32'h200, 5'd7, 1'b1, 32'h201};
    for (int i = 0; i < 5; i++) begin
      chk("z_hold_valid", 128'(ic.rd_valid), 128'(1));
      chk("z_hold_data", 128'(ic.rd_data), 128'(exp_c));
      tick();
    end
    ic.rd_ready = 1'b1;
    tick();
    ic.rd_ready = 1'b0;
    chk("z_idle", 128'(st_c), 128'(0));

    // async reset mid-POST
    trig_pc = 32'h8;
    do_arm();
    capture(32'h0);
    capture(32'h4);
    capture(32'h8);
    chk("r_post", 128'(st_a), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("r_state", 128'(st_a), 128'(0));
    chk("r_count", 128'(cnt_a), 128'(0));
    chk("r_valid", 128'(ia.rd_valid), 128'(0));
    reset = 1'b1;
    tick();

    // arm while frozen restarts
    trig_pc = 32'h0;
    do_arm();
    capture(32'h0);
    capture(32'h4);
    capture(32'h8);
    chk("af_frozen", 128'(st_a), 128'(3));
    chk("af_count", 128'(cnt_a), 128'(3));
    do_arm();
    chk("af_armed", 128'(st_a), 128'(1));
    chk("af_count0", 128'(cnt_a), 128'(0));
    chk("af_trg0", 128'(trg_a), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter DEPTH, default 16, trace entries; power of two, at least 2.
REQ-003 SHALL have parameter POST_COUNT, default 4, entries captured after the trigger entry; range 0 to DEPTH-1.
REQ-004 SHALL have parameter WRAP, default 1; 1 overwrites oldest entry when full, 0 drops new captures when full.
REQ-005 SHALL have ports: clk input 1, sole clock, rising edge; reset input 1, asynchronous, active-low.
REQ-006 SHALL have capture ports: cap_valid input 1, retire strobe; cap_pc input XLEN; cap_inst input 32; cap_rd input 5; cap_regwrite input 1; cap_wdata input XLEN, writeback value.
REQ-007 SHALL have control ports: arm input 1, pulse; trig_en input 1, PC-match enable; trig_pc input XLEN; force_trig input 1, pulse.
REQ-008 SHALL have readout ports: rd_valid output 1; rd_ready input 1; rd_data output 2*XLEN+38, packed {pc, inst, rd, regwrite, wdata}, pc in MSBs.
REQ-009 SHALL have status ports: state output 2; count output log2(DEPTH)+1; triggered output 1; overflow output 1, sticky.

Function
REQ-010 SHALL implement states IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-011 In IDLE, captures SHALL be ignored; arm SHALL clear wr_ptr, rd_ptr, count, triggered and overflow, then enter ARMED next cycle.
REQ-012 In ARMED and POST, each cycle with cap_valid SHALL write one entry at wr_ptr, with wr_ptr incrementing modulo DEPTH.
REQ-013 When count equals DEPTH and WRAP=1, a capture SHALL overwrite the oldest entry, advance rd_ptr, hold count at DEPTH, and set overflow.
REQ-014 When count equals DEPTH and WRAP=0, a capture SHALL be dropped, leave pointers unchanged, and set overflow.
REQ-015 Trigger SHALL fire in ARMED on cap_valid with trig_en and cap_pc==trig_pc, or on force_trig in any cycle; the matching entry itself SHALL be captured.
REQ-016 On trigger, triggered SHALL be 1 from the next cycle; the post counter SHALL load POST_COUNT.
REQ-017 On trigger, the next state SHALL be POST if POST_COUNT>0, else FROZEN.
REQ-018 In POST, each capture SHALL decrement the post counter; the capture taking it to 0 SHALL move to FROZEN next cycle.
REQ-019 In POST, a dropped capture (REQ-014) SHALL still decrement the post counter.
REQ-020 In FROZEN, captures SHALL be ignored; rd_valid SHALL equal (count!=0); rd_data SHALL be the entry at rd_ptr, oldest first.
REQ-021 A readout handshake (rd_valid and rd_ready) SHALL advance rd_ptr modulo DEPTH and decrement count.
REQ-022 When the handshake takes count to 0, the next state SHALL be IDLE; FROZEN with count 0 on entry SHALL go to IDLE next cycle.
REQ-023 arm in ARMED, POST or FROZEN SHALL restart as in REQ-011, discarding contents; arm SHALL take priority over a same-cycle trigger or handshake.
REQ-024 rd_valid SHALL be 0 outside FROZEN.
REQ-025 Latency: an entry written on edge N SHALL be readable from cycle N+1.

Reset
REQ-026 Reset low SHALL asynchronously force state=IDLE and clear wr_ptr, rd_ptr, count, post counter, triggered, overflow and rd_valid.
REQ-027 rd_data SHALL be don't-care after reset; storage SHALL not be reset.
REQ-028 Reset mid-capture or mid-readout SHALL discard the trace; deassertion SHALL be synchronised by the integrator.

Structure
REQ-029 Package trace_pkg SHALL hold the state enumeration, entry field offsets and the entry-width function of XLEN.
REQ-030 Sub-module trace_ram SHALL be the DEPTH x entry-width storage, with one synchronous write port and one asynchronous read port.
REQ-031 Control FSM and pointers SHALL stay in commit_trace_buffer.

Verification (DEPTH=8, POST_COUNT=2, XLEN=32)
REQ-032 arm, trig_pc=0x10, PCs 0x0,0x4,..,0x18 one per cycle -> FROZEN after 0x18; readout 0x0..0x18 in order, 7 entries, overflow=0.
REQ-033 WRAP=1, trig_pc=0x40, PCs 0x0..0x48 step 4 -> count=8, overflow=1, readout 0x2C..0x48.
REQ-034 WRAP=0, trig_en=0, 10 captures then force_trig and 2 more captures -> count=8, readout PCs of first 8 captures, overflow=1.
REQ-035 POST_COUNT=0, trigger on first capture -> FROZEN next cycle, count=1; rd_ready held low 5 cycles keeps rd_valid=1 and rd_data stable.
REQ-036 Reset low mid-POST -> state=IDLE, count=0, rd_valid=0 immediately, without waiting for a clock edge; arm during FROZEN -> ARMED, count=0.
